ofdm_rxseq: RTL and testbench
=============================

Name: ofdm_rxseq

Overview:
- Receive frame sequencer for the OFDM demodulator path. Consumes the carrier-detect and null/symbol-sync flags produced after the CORDIC stage and walks each received frame: arm, null search, timing lock, then per-symbol cyclic-prefix skip and FFT window.
- Drives the sync-detector init strobe and the FFT input-window/valid signals, and counts symbols.
- Configured and polled through the shared 16-bit I/O bus.

Parameters:
- NW, 11, FFT-size counter width (max FFT 2048)
- CW, 9, cyclic-prefix counter width
- SW, 8, symbol counter width
- TW, 16, null-search timeout counter width

Ports:
- clk  in  1  sample clock
- rst  in  1  asynchronous, active-low reset
- iocs  in  1  select this module
- ioaddr  in  3  port address; ports 0-2 used
- din  in  16  I/O write data
- iowr  in  1  write strobe
- dout  out  16  registered status read data
- iv  in  1  sample valid (CORDIC output rate); all counters advance only when iv=1
- dcd  in  1  data carrier detect
- fcd  in  1  full carrier detect
- start  in  1  null-symbol detected pulse
- sync  in  1  symbol-timing (CP end) pulse
- xmt  in  1  transmit mode; forces IDLE
- init  out  1  one-clock init pulse to the sync/null detector
- sof  out  1  one-clock start-of-frame pulse
- win  out  1  FFT sample-window valid (qualified by iv)
- sow  out  1  one-clock pulse on the first windowed sample of each symbol
- symnum  out  SW  index of the current symbol
- eof  out  1  one-clock end-of-frame pulse
- active  out  1  frame in progress (state is not IDLE/ARM)

Behaviour:
- Config writes (iocs & iowr):
  - port 0: din[NW-1:0] = FFT size-1
  - port 1: din[15:8] = symbols per frame-1, din[CW-1:0] = CP length-1
  - port 2: din[TW-1:0] = null-search timeout in samples
- Reset values: FFT size-1 = 1023, CP length-1 = 127, symbols-1 = 15, timeout = 4096.
- Shadow copies of all config are latched on sof. A write mid-frame takes effect at the next frame.
- Reset state: all outputs 0, state IDLE, counters 0, dout 0.
- States and transitions:
  - IDLE: go to ARM when xmt=0 and dcd=1.
  - ARM: wait for fcd=1. Leaving ARM emits init for 1 clk and enters NULL.
  - NULL: counts iv samples.
    - start=1 -> ALIGN.
    - Counter reaching the timeout -> IDLE, sets the TO sticky flag, pulses init.
  - ALIGN: sync=1 -> SYM, with sof=1 on the same clock.
    - cp counter loads CP length-1; symnum=0.
    - The same NULL timeout applies here.
  - SYM: per iv sample.
    - CP phase: decrement cp; win=0.
    - When cp reaches 0, the window phase starts on the next iv: win=1; sow=1 on the first such sample; the FFT counter counts 0..N-1.
    - After the last windowed sample (FFT counter = N-1):
      - if symnum = symbols-1: eof=1, pulse init, state -> ARM;
      - else symnum+1 and the CP phase reloads.
- Precedence and aborts:
  - xmt=1 in any state -> IDLE next clock.
  - dcd=0 in ALIGN or SYM -> IDLE, sets the LOS sticky flag, pulses init. eof is not asserted on abort.
  - start and sync in the same cycle in NULL: start is taken; sync is ignored until ALIGN.
  - sync during SYM is ignored (timing is free-running within a frame).
- Registered outputs: win, sow, sof and eof are registered, 1 clk after the iv sample that causes them. win is high only on clocks where the delayed iv is high.
- Reads: dout is registered 1 clk after address.
  - ioaddr[1:0]=0: {state[2:0], 5'b0, symnum}
  - 1: {14'b0, LOS, TO}. Reading port 1 clears both flags; a set and a clear in the same clock resolve to set.
- Wrap-around: symnum and the counters never wrap within a frame. The timeout counter saturates.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=0, ARM=1, NULL=2, ALIGN=3, SYM=4;
  - port address constants;
  - reset-default constants.
- One natural sub-module: ofdm_symtmr. It is the CP/FFT-window down/up counter pair with load, iv enable and done pulse, reused per symbol.

Test Plan:
- Reset then config N=64, CP=16, 4 symbols, dcd=fcd=1, iv every clk, start at t0, sync at t0+200 -> sof 1 clk later; 4 symbols each of 16 win=0 plus 64 win=1 samples; sow ×4; symnum 0..3; eof after sample 320; state ARM.
- iv every 3rd clk, same config -> identical sample counts; win asserted only on iv clocks.
- dcd drops on symbol 2 -> state IDLE next clk, LOS=1, one init pulse, no eof; read port 1 returns 0x0002, then 0x0000.
- No start for timeout=100 samples in NULL -> IDLE, TO=1, init pulse.
- Write port 1 mid-frame (CP=8) -> current frame keeps CP=16; next frame uses CP=8.
- Assert rst low mid-SYM, asynchronously -> all outputs 0 immediately, state IDLE; xmt=1 during SYM -> IDLE next clk.

Source files
------------

// File: rtl/ofdm_rxseq_pkg.sv
// Shared definitions for the OFDM receive frame sequencer: state encoding,
// I/O port map and power-on configuration defaults.
package ofdm_rxseq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARM   = 3'd1,
      ST_NULL  = 3'd2,
      ST_ALIGN = 3'd3,
      ST_SYM   = 3'd4
   } state_t;

   // Write ports decode the full address, reads only look at the low two bits
   localparam logic [2:0] PORT_FFT = 3'd0;
   localparam logic [2:0] PORT_FRM = 3'd1;
   localparam logic [2:0] PORT_TMO = 3'd2;
   localparam logic [1:0] RD_STAT  = 2'd0;
   localparam logic [1:0] RD_FLAG  = 2'd1;

   localparam int DEF_FFTM1 = 1023;
   localparam int DEF_CPM1  = 127;
   localparam int DEF_SYMM1 = 15;
   localparam int DEF_TMO   = 4096;

endpackage

// File: rtl/ofdm_symtmr.sv
// Per-symbol timer: cyclic-prefix down-counter followed by FFT-window up-counter,
// advancing only on enabled samples and rearming itself for the next symbol.
module ofdm_symtmr
   import ofdm_rxseq_pkg::*;
#(
   parameter int NW = 11,
   parameter int CW = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          en,
   input  logic [CW-1:0] cplen,
   input  logic [NW-1:0] fftlen,
   output logic          wsamp,
   output logic          first,
   output logic          last
);

   logic [CW-1:0] cpcnt;
   logic [NW-1:0] fcnt;
   logic          inwin;

   // The sample on which cpcnt is 0 is still prefix; the window opens on the next one
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cpcnt <= '0;
         fcnt  <= '0;
         inwin <= 1'b0;
      end else if (load) begin
         cpcnt <= cplen;
         fcnt  <= '0;
         inwin <= 1'b0;
      end else if (en) begin
         if (!inwin) begin
            if (cpcnt == '0) begin
               inwin <= 1'b1;
               fcnt  <= '0;
            end else begin
               cpcnt <= cpcnt - 1'b1;
            end
         end else if (fcnt == fftlen) begin
            inwin <= 1'b0;
            cpcnt <= cplen;
         end else begin
            fcnt <= fcnt + 1'b1;
         end
      end
   end

   assign wsamp = en & inwin;
   assign first = wsamp & (fcnt == '0);
   assign last  = wsamp & (fcnt == fftlen);

endmodule

// File: rtl/ofdm_rxseq.sv
// OFDM receive frame sequencer: carrier arm, null search, timing lock, then
// per-symbol prefix skip and FFT window, with a small 16-bit config/status port.
module ofdm_rxseq
   import ofdm_rxseq_pkg::*;
#(
   parameter int NW = 11,
   parameter int CW = 9,
   parameter int SW = 8,
   parameter int TW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          iocs,
   input  logic [2:0]    ioaddr,
   input  logic [15:0]   din,
   input  logic          iowr,
   output logic [15:0]   dout,
   input  logic          iv,
   input  logic          dcd,
   input  logic          fcd,
   input  logic          start,
   input  logic          sync,
   input  logic          xmt,
   output logic          init,
   output logic          sof,
   output logic          win,
   output logic          sow,
   output logic [SW-1:0] symnum,
   output logic          eof,
   output logic          active
);

   state_t        state;
   logic [NW-1:0] cfgFft, shFft;
   logic [CW-1:0] cfgCp, shCp, tmrCp;
   logic [SW-1:0] cfgSym, shSym;
   logic [TW-1:0] cfgTmo, toc, tnext;
   logic          losf, tof;
   logic          sofNow, symEn, tmoHit, rdFlags;
   logic          tmrWin, tmrFirst, tmrLast;

   assign sofNow  = (state == ST_ALIGN) & sync & ~xmt & dcd;
   assign symEn   = iv & (state == ST_SYM);
   assign tnext   = (toc == '1) ? toc : toc + 1'b1;
   assign tmoHit  = iv & (tnext >= cfgTmo);
   assign rdFlags = iocs & ~iowr & (ioaddr[1:0] == RD_FLAG);
   assign active  = (state == ST_NULL) | (state == ST_ALIGN) | (state == ST_SYM);
   // The shadow is being written on the sof clock, so the first load takes the live value
   assign tmrCp   = sofNow ? cfgCp : shCp;

   ofdm_symtmr #(.NW(NW), .CW(CW)) u_symtmr (
      .clk    (clk),
      .rst    (rst),
      .load   (sofNow),
      .en     (symEn),
      .cplen  (tmrCp),
      .fftlen (shFft),
      .wsamp  (tmrWin),
      .first  (tmrFirst),
      .last   (tmrLast)
   );

   // The symbols field shares the upper byte of port 1, so CP is set from din[7:0]
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfgFft <= NW'(DEF_FFTM1);
         cfgCp  <= CW'(DEF_CPM1);
         cfgSym <= SW'(DEF_SYMM1);
         cfgTmo <= TW'(DEF_TMO);
      end else if (iocs & iowr) begin
         case (ioaddr)
            PORT_FFT: cfgFft <= din[NW-1:0];
            PORT_FRM: begin
               cfgSym <= SW'(din[15:8]);
               cfgCp  <= CW'(din[7:0]);
            end
            PORT_TMO: cfgTmo <= din[TW-1:0];
            default: ;
         endcase
      end
   end

   // Transmit mode overrides everything, then loss of carrier, then normal sequencing.
   // The timeout is only used before sof, so it runs from the live register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_IDLE;
         init   <= 1'b0;
         sof    <= 1'b0;
         eof    <= 1'b0;
         win    <= 1'b0;
         sow    <= 1'b0;
         symnum <= '0;
         toc    <= '0;
         losf   <= 1'b0;
         tof    <= 1'b0;
         shFft  <= NW'(DEF_FFTM1);
         shCp   <= CW'(DEF_CPM1);
         shSym  <= SW'(DEF_SYMM1);
      end else begin
         init <= 1'b0;
         sof  <= 1'b0;
         eof  <= 1'b0;
         win  <= 1'b0;
         sow  <= 1'b0;
         if (rdFlags) begin
            losf <= 1'b0;
            tof  <= 1'b0;
         end
         if (xmt) begin
            state <= ST_IDLE;
         end else if (!dcd && (state == ST_ALIGN || state == ST_SYM)) begin
            state <= ST_IDLE;
            losf  <= 1'b1;
            init  <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: if (dcd) state <= ST_ARM;
               ST_ARM: begin
                  if (fcd) begin
                     state <= ST_NULL;
                     init  <= 1'b1;
                     toc   <= '0;
                  end
               end
               ST_NULL: begin
                  if (start) begin
                     state <= ST_ALIGN;
                     toc   <= '0;
                  end else if (iv) begin
                     toc <= tnext;
                     if (tmoHit) begin
                        state <= ST_IDLE;
                        tof   <= 1'b1;
                        init  <= 1'b1;
                     end
                  end
               end
               ST_ALIGN: begin
                  if (sync) begin
                     state  <= ST_SYM;
                     sof    <= 1'b1;
                     symnum <= '0;
                     shFft  <= cfgFft;
                     shCp   <= cfgCp;
                     shSym  <= cfgSym;
                  end else if (iv) begin
                     toc <= tnext;
                     if (tmoHit) begin
                        state <= ST_IDLE;
                        tof   <= 1'b1;
                        init  <= 1'b1;
                     end
                  end
               end
               ST_SYM: begin
                  win <= tmrWin;
                  sow <= tmrFirst;
                  if (tmrLast) begin
                     if (symnum == shSym) begin
                        eof   <= 1'b1;
                        init  <= 1'b1;
                        state <= ST_ARM;
                     end else begin
                        symnum <= symnum + 1'b1;
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout <= '0;
      end else if (iocs & ~iowr) begin
         case (ioaddr[1:0])
            RD_STAT: dout <= 16'({state, 5'b0, symnum});
            RD_FLAG: dout <= {14'b0, losf, tof};
            default: dout <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_ofdm_rxseq.sv
// Directed bench for ofdm_rxseq: full frames at two sample rates, mid-frame
// reconfiguration, carrier loss, null timeout, async reset and transmit override.
module tb_ofdm_rxseq;

   logic        clk = 1'b0;
   logic        rst, iocs, iowr, iv, dcd, fcd, start, sync, xmt;
   logic [2:0]  ioaddr;
   logic [15:0] din, dout, rd;
   logic        init, sof, win, sow, eof, active;
   logic [7:0]  symnum;

   int checks = 0;
   int errors = 0;
   int cntWin, cntSow, cntSof, cntEof, cntInit, winBad, symBad, ivSinceSof, sowGap, eofAt, n;
   logic sowSeen;

   ofdm_rxseq dut (
      .clk(clk), .rst(rst), .iocs(iocs), .ioaddr(ioaddr), .din(din), .iowr(iowr),
      .dout(dout), .iv(iv), .dcd(dcd), .fcd(fcd), .start(start), .sync(sync),
      .xmt(xmt), .init(init), .sof(sof), .win(win), .sow(sow), .symnum(symnum),
      .eof(eof), .active(active)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clearStats();
      cntWin = 0; cntSow = 0; cntSof = 0; cntEof = 0; cntInit = 0;
      winBad = 0; symBad = 0; ivSinceSof = 0; sowGap = 0; eofAt = 0; sowSeen = 1'b0;
   endtask

   // One clock of stimulus, then sample just after the edge and accumulate statistics
   task automatic applyStimulus(input logic ivv, input logic st, input logic sy);
      @(negedge clk);
      iv = ivv; start = st; sync = sy; iocs = 1'b0; iowr = 1'b0;
      @(posedge clk); #1;
      if (sof) begin
         cntSof++; ivSinceSof = 0; sowSeen = 1'b0;
      end else if (ivv) begin
         ivSinceSof++;
      end
      if (win) begin
         cntWin++;
         if (!ivv) winBad++;
      end
      if (sow) begin
         if (!sowSeen) begin
            sowGap = ivSinceSof; sowSeen = 1'b1;
         end
         if (symnum != 8'(cntSow)) symBad++;
         cntSow++;
      end
      if (eof) begin
         cntEof++; eofAt = ivSinceSof;
      end
      if (init) cntInit++;
   endtask

   task automatic ioWrite(input logic [2:0] addr, input logic [15:0] data);
      @(negedge clk);
      iv = 1'b0; start = 1'b0; sync = 1'b0;
      iocs = 1'b1; iowr = 1'b1; ioaddr = addr; din = data;
      @(posedge clk); #1;
      iocs = 1'b0; iowr = 1'b0;
   endtask

   task automatic ioRead(input logic [2:0] addr, output logic [15:0] data);
      @(negedge clk);
      iv = 1'b0; start = 1'b0; sync = 1'b0;
      iocs = 1'b1; iowr = 1'b0; ioaddr = addr;
      @(posedge clk); #1;
      data = dout;
      iocs = 1'b0;
   endtask

   // Arm into NULL, start at t0, sync at t0+200
   task automatic startFrame(input int p);
      fcd = 1'b1;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         if (active) break;
      end
      checkOutput("enter_null", active, 1);
      fcd = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0);
      for (int i = 1; i < 200; i++) applyStimulus((i % p) == 0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("sof_pulse", sof, 1);
   endtask

   task automatic runToEof(input int p, input int bound);
      for (int i = 0; i < bound; i++) begin
         applyStimulus((i % p) == 0, 1'b0, 1'b0);
         if (eof) break;
      end
   endtask

   task automatic waitSow(input int k);
      for (int i = 0; i < 1000; i++) begin
         if (cntSow >= k) break;
         applyStimulus(1'b1, 1'b0, 1'b0);
      end
      checkOutput("sow_reached", cntSow >= k, 1);
   endtask

   task automatic checkFrame(input string p, input int expGap, input int expEofAt);
      checkOutput({p, "_sof"}, cntSof, 1);
      checkOutput({p, "_win"}, cntWin, 256);
      checkOutput({p, "_sow"}, cntSow, 4);
      checkOutput({p, "_eof"}, cntEof, 1);
      checkOutput({p, "_init"}, cntInit, 2);
      checkOutput({p, "_winiv"}, winBad, 0);
      checkOutput({p, "_symnum"}, symBad, 0);
      checkOutput({p, "_cpgap"}, sowGap, expGap);
      checkOutput({p, "_eofat"}, eofAt, expEofAt);
   endtask

   initial begin
      rst = 1'b0; iocs = 1'b0; iowr = 1'b0; ioaddr = '0; din = '0;
      iv = 1'b0; dcd = 1'b0; fcd = 1'b0; start = 1'b0; sync = 1'b0; xmt = 1'b0;
      clearStats();
      repeat (3) @(negedge clk);
      checkOutput("rst_dout", dout, 0);
      checkOutput("rst_active", active, 0);
      checkOutput("rst_init", init, 0);
      checkOutput("rst_win", win, 0);
      checkOutput("rst_symnum", symnum, 0);
      rst = 1'b1;

      // Frame 1: N=64, CP=16, 4 symbols, iv every clock
      ioWrite(3'd0, 16'd63);
      ioWrite(3'd1, 16'h030F);
      dcd = 1'b1;
      clearStats();
      startFrame(1);
      runToEof(1, 1000);
      checkFrame("f1", 17, 320);
      checkOutput("f1_active", active, 0);
      ioRead(3'd0, rd);
      checkOutput("f1_stat", rd, 16'h2003);

      // Frame 2: iv every third clock, CP=8 written mid-frame
      clearStats();
      startFrame(3);
      ioWrite(3'd1, 16'h0307);
      runToEof(3, 3000);
      checkFrame("f2", 17, 320);

      // Frame 3 picks up CP=8
      clearStats();
      startFrame(1);
      runToEof(1, 1000);
      checkFrame("f3", 9, 288);

      // Carrier loss during symbol 2
      clearStats();
      startFrame(1);
      waitSow(3);
      repeat (10) applyStimulus(1'b1, 1'b0, 1'b0);
      cntInit = 0; cntEof = 0;
      dcd = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("los_active", active, 0);
      checkOutput("los_win", win, 0);
      repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("los_init", cntInit, 1);
      checkOutput("los_eof", cntEof, 0);
      ioRead(3'd1, rd);
      checkOutput("los_flag", rd, 16'h0002);
      ioRead(3'd1, rd);
      checkOutput("los_clear", rd, 16'h0000);
      dcd = 1'b1;

      // Null-search timeout of 100 samples
      ioWrite(3'd2, 16'd100);
      clearStats();
      fcd = 1'b1;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         if (active) break;
      end
      fcd = 1'b0;
      n = 0;
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         n++;
         if (!active) break;
      end
      checkOutput("to_samples", n, 100);
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("to_init", cntInit, 2);
      ioRead(3'd1, rd);
      checkOutput("to_flag", rd, 16'h0001);
      ioWrite(3'd2, 16'd4096);

      // Asynchronous reset in the middle of symbol 1
      clearStats();
      startFrame(1);
      waitSow(2);
      repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("prerst_win", win, 1);
      checkOutput("prerst_symnum", symnum, 1);
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      checkOutput("arst_win", win, 0);
      checkOutput("arst_active", active, 0);
      checkOutput("arst_symnum", symnum, 0);
      checkOutput("arst_pulses", {init, sof, sow, eof}, 0);
      checkOutput("arst_dout", dout, 0);
      @(negedge clk);
      rst = 1'b1;

      // Transmit mode during SYM
      ioWrite(3'd0, 16'd63);
      ioWrite(3'd1, 16'h030F);
      clearStats();
      startFrame(1);
      waitSow(1);
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
      xmt = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("xmt_active", active, 0);
      checkOutput("xmt_win", win, 0);
      ioRead(3'd0, rd);
      checkOutput("xmt_stat", rd, 16'h0000);
      xmt = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
